// File: rtl/mem_pkg.sv
// Shared types and widths for the SRAM memory-access stage.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      DONE
   } sram_state_t;

   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 16;

endpackage : mem_pkg

// File: rtl/sram_mem_stage.sv
// Memory-access stage: splits one 32-bit load/store into two 16-bit accesses
// on an asynchronous SRAM, freezing the pipeline through ready while busy.
module sram_mem_stage
   import mem_pkg::*;
#(
   parameter int unsigned BASE_ADDR     = 1024,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   MEM_R_EN,
   input  logic                   MEM_W_EN,
   input  logic [31:0]            ALU_Res,
   input  logic [31:0]            VAL_RM,
   output logic                   ready,
   output logic [31:0]            mem_rdata,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic [SRAM_DATA_W-1:0] SRAM_DQ_OUT,
   input  logic [SRAM_DATA_W-1:0] SRAM_DQ_IN,
   output logic                   SRAM_DQ_OE,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_OE_N
);

   localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

   sram_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      offset;
   logic [16:0]      word_idx;
   logic             request;
   logic             phase_last;
   logic             unused_offset_bits;

   // Byte offset into the SRAM window; alignment bits and the bits above the
   // 17-bit word index are simply dropped.
   assign offset             = ALU_Res - 32'(BASE_ADDR);
   assign word_idx           = offset[18:2];
   assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

   assign request    = MEM_R_EN | MEM_W_EN;
   assign phase_last = (cnt == LAST_CNT);

   // Freeze upstream from the very cycle a request appears until DONE.
   assign ready = ((state == IDLE) && !request) || (state == DONE);

   // Access sequencer with registered SRAM pins; write wins when both enables
   // are set. Request inputs are held stable by the frozen upstream register.
   // NOTE: every register here uses <= so all state updates see pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         mem_rdata   <= '0;
         SRAM_ADDR   <= '0;
         SRAM_DQ_OUT <= '0;
         SRAM_DQ_OE  <= 1'b0;
         SRAM_WE_N   <= 1'b1;
         SRAM_OE_N   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  state     <= LO;
                  cnt       <= '0;
                  SRAM_ADDR <= {word_idx, 1'b0};
                  if (MEM_W_EN) begin
                     SRAM_DQ_OUT <= VAL_RM[15:0];
                     SRAM_DQ_OE  <= 1'b1;
                     SRAM_WE_N   <= 1'b0;
                     SRAM_OE_N   <= 1'b1;
                  end else begin
                     SRAM_DQ_OE <= 1'b0;
                     SRAM_WE_N  <= 1'b1;
                     SRAM_OE_N  <= 1'b0;
                  end
               end
            end
            LO: begin
               if (phase_last) begin
                  state     <= HI;
                  cnt       <= '0;
                  SRAM_ADDR <= {word_idx, 1'b1};
                  if (MEM_W_EN) begin
                     SRAM_DQ_OUT <= VAL_RM[31:16];
                  end else begin
                     mem_rdata[15:0] <= SRAM_DQ_IN;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HI: begin
               if (phase_last) begin
                  state      <= DONE;
                  cnt        <= '0;
                  SRAM_DQ_OE <= 1'b0;
                  SRAM_WE_N  <= 1'b1;
                  SRAM_OE_N  <= 1'b1;
                  if (!MEM_W_EN) begin
                     mem_rdata[31:16] <= SRAM_DQ_IN;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : sram_mem_stage
